// File: rtl/brm_sched_pkg.sv
// Shared types and constants for the backup-RAM save scheduler.
// Status byte layout: {err, 0, state[1:0], dirty[1:0], mask[1:0]}.
package brm_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    REQ    = 2'd2,
    SAVING = 2'd3
  } brm_state_e;

  localparam int REG_EXP = 0;
  localparam int REG_HUC = 1;

  localparam int ST_MASK  = 0;
  localparam int ST_DIRTY = 2;
  localparam int ST_STATE = 4;
  localparam int ST_ERR   = 7;

  function automatic logic [7:0] mk_status(
    input logic       e,
    input logic [1:0] st,
    input logic [1:0] d,
    input logic [1:0] m
  );
    logic [7:0] s;
    s = '0;
    s[ST_ERR] = e;
    s[ST_STATE +: 2] = st;
    s[ST_DIRTY +: 2] = d;
    s[ST_MASK +: 2] = m;
    return s;
  endfunction

endpackage

// File: rtl/brm_ms_timer.sv
// Saturating millisecond down-counter.
// o_zero flags that the count will be zero after this clock.
module brm_ms_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  input  logic             i_tick,
  input  logic             i_en,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nxt;

  always_comb begin
    w_nxt = r_cnt;
    if (i_load)
      w_nxt = i_val;
    else if (i_en && i_tick && (r_cnt != '0))
      w_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else
      r_cnt <= w_nxt;
  end

  assign o_zero = (w_nxt == '0);

endmodule

// File: rtl/brm_save_sched.sv
// Backup-RAM persistence scheduler: dirty tracking, quiet/defer
// timing and the request/ack/done handshake with the MCU loader.
module brm_save_sched
  import brm_sched_pkg::*;
#(
  parameter int QUIET_MS     = 500,
  parameter int MAX_DEFER_MS = 5000,
  parameter int TIMEOUT_MS   = 2000,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       brm_on,
  input  logic       tick_ms,
  input  logic       wr_exp,
  input  logic       wr_huc,
  input  logic       force_save,
  input  logic       save_ack,
  input  logic       save_done,
  output logic       save_req,
  output logic [1:0] save_mask,
  output logic       busy,
  output logic [7:0] status
);

  brm_state_e r_state;
  logic [1:0] r_dirty;
  logic [1:0] r_mask;
  logic       r_req;
  logic       r_busy;
  logic       r_err;

  logic [1:0] w_wr;
  logic [1:0] w_dset;
  logic       w_any_wr;
  logic       w_q_zero;
  logic       w_d_zero;
  logic       w_t_zero;
  logic       w_tmo;
  logic       w_go;
  logic       w_q_ld;
  logic       w_d_ld;
  logic       w_t_ld;

  always_comb begin
    w_wr = '0;
    w_wr[REG_EXP] = wr_exp;
    w_wr[REG_HUC] = wr_huc;
  end

  assign w_dset   = r_dirty | w_wr;
  assign w_any_wr = |w_wr;
  assign w_tmo    = (r_state == SAVING) & w_t_zero & ~save_done;
  assign w_go     = (r_state == ARMED)
                  & (w_q_zero | w_d_zero | force_save);

  // Defer only arms on the clean-to-dirty edge; later writes leave it alone.
  assign w_q_ld = ~brm_on | w_any_wr | w_tmo;
  assign w_d_ld = ~brm_on | (~|r_dirty & (w_any_wr | w_tmo));
  assign w_t_ld = ~brm_on | ((r_state == REQ) & save_ack);

  brm_ms_timer #(.CNT_W(CNT_W)) u_quiet (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_q_ld),
    .i_val  (brm_on ? CNT_W'(QUIET_MS) : '0),
    .i_tick (tick_ms),
    .i_en   (|r_dirty),
    .o_zero (w_q_zero)
  );

  brm_ms_timer #(.CNT_W(CNT_W)) u_defer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_d_ld),
    .i_val  (brm_on ? CNT_W'(MAX_DEFER_MS) : '0),
    .i_tick (tick_ms),
    .i_en   (1'b1),
    .o_zero (w_d_zero)
  );

  brm_ms_timer #(.CNT_W(CNT_W)) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_t_ld),
    .i_val  (brm_on ? CNT_W'(TIMEOUT_MS) : '0),
    .i_tick (tick_ms),
    .i_en   (r_state == SAVING),
    .o_zero (w_t_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_dirty <= '0;
      r_mask  <= '0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else if (!brm_on) begin
      r_state <= IDLE;
      r_dirty <= '0;
      r_mask  <= '0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_dirty <= w_dset;
      case (r_state)
        IDLE: begin
          if (w_any_wr)
            r_state <= ARMED;
        end
        ARMED: begin
          if (w_go) begin
            r_state <= REQ;
            r_mask  <= w_dset;
            r_dirty <= '0;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        REQ: begin
          if (save_ack) begin
            r_state <= SAVING;
            r_req   <= 1'b0;
          end
        end
        SAVING: begin
          if (save_done) begin
            r_state <= (|w_dset) ? ARMED : IDLE;
            r_mask  <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
          end else if (w_tmo) begin
            r_state <= ARMED;
            r_dirty <= w_dset | r_mask;
            r_mask  <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign save_req  = r_req;
  assign save_mask = r_mask;
  assign busy      = r_busy;
  assign status    = mk_status(r_err, r_state, r_dirty, r_mask);

endmodule
